// File: rtl/seq_adder.sv
// -----------------------------------------------------------------------------
// seq_adder
//   Multi-cycle chunked ripple adder: {Cout, s} = a + b + Cin.
//   The operands are captured on the accept edge. One CHUNK-bit slice is then
//   summed per cycle, from the least significant slice upwards, with the carry
//   held in a register between slices. After the last slice the result is held
//   in DONE until the consumer takes it.
//
//   Ports
//     clk        in   1      rising-edge clock
//     reset      in   1      synchronous, active-high reset
//     in_valid   in   1      a, b, Cin valid
//     in_ready   out  1      block accepts operands this cycle (IDLE)
//     a, b       in   WIDTH  addends
//     Cin        in   1      carry-in
//     out_valid  out  1      s and Cout valid (DONE)
//     out_ready  in   1      consumer accepts the result
//     s          out  WIDTH  sum, modulo 2^WIDTH
//     Cout       out  1      carry-out of bit WIDTH-1
//     ovf        out  1      signed overflow (only with SEQ_ADDER_OVF_EN)
//
//   Parameters
//     WIDTH  operand/result width
//     CHUNK  bits summed per cycle; WIDTH must be a multiple of CHUNK
//
//   Build option
//     SEQ_ADDER_OVF_EN  adds the ovf output and its register.
// -----------------------------------------------------------------------------
module seq_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             Cout
`ifdef SEQ_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    // Reject configurations where the slices would not tile the word exactly.
    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("seq_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
`ifdef SEQ_ADDER_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    // Slice views of the captured operands, indexed by the chunk counter.
    logic [CHUNK-1:0]  a_chunk [NCHUNK];
    logic [CHUNK-1:0]  b_chunk [NCHUNK];

    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
            assign a_chunk[gi] = a_q[gi*CHUNK +: CHUNK];
            assign b_chunk[gi] = b_q[gi*CHUNK +: CHUNK];
        end
    endgenerate

    logic [CHUNK-1:0]  a_sel;
    logic [CHUNK-1:0]  b_sel;
    logic [CHUNK:0]    chunk_sum;   // {carry out of slice, slice sum}
    logic              run_step;

    assign a_sel     = a_chunk[idx_q];
    assign b_sel     = b_chunk[idx_q];
    assign chunk_sum = {1'b0, a_sel} + {1'b0, b_sel} + {{CHUNK{1'b0}}, carry_q};
    assign run_step  = (state_q == ST_RUN);

    // Only the slice selected by the counter is written during RUN; all other
    // slices keep their value, so s holds the previous result until it is
    // overwritten slice by slice.
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_s_next
            assign s_d[gi*CHUNK +: CHUNK] =
                (run_step && (idx_q == IDX_W'(gi))) ? chunk_sum[CHUNK-1:0]
                                                    : s_q[gi*CHUNK +: CHUNK];
        end
    endgenerate

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SEQ_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = Cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                carry_d = chunk_sum[CHUNK];
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = chunk_sum[CHUNK];
`ifdef SEQ_ADDER_OVF_EN
                    // Top slice's MSB is the result sign bit.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
`endif
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SEQ_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign s         = s_q;
    assign Cout      = cout_q;
`ifdef SEQ_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_adder.sv
// -----------------------------------------------------------------------------
// tb_seq_adder
//   Self-checking bench for seq_adder. Expected results come from plain
//   wide-integer arithmetic on the operands; each transaction prints one line.
// -----------------------------------------------------------------------------
module tb_seq_adder;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam longint SMAX = (64'sd1 <<< (WIDTH - 1)) - 64'sd1;
    localparam longint SMIN = -SMAX - 64'sd1;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic             cin_i     = 1'b0;
    logic [WIDTH-1:0] a_i       = '0;
    logic [WIDTH-1:0] b_i       = '0;
    logic             in_ready;
    logic             out_valid;
    logic             cout_o;
    logic [WIDTH-1:0] s_o;
`ifdef SEQ_ADDER_OVF_EN
    logic             ovf_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .Cin       (cin_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s_o),
        .Cout      (cout_o)
`ifdef SEQ_ADDER_OVF_EN
        ,
        .ovf       (ovf_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction: offer operands, scramble inputs after the accept
    // edge, measure latency, check the result, stall the consumer for `hold`
    // cycles (with a competing in_valid), then complete the handshake.
    task automatic do_op(input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                         input logic c_v, input int hold);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] exp_s;
        logic             exp_c;
        logic             exp_o;
        longint           ssum;
        int               lat;
        int               guard;

        full  = {1'b0, a_v} + {1'b0, b_v} + {{WIDTH{1'b0}}, c_v};
        exp_s = full[WIDTH-1:0];
        exp_c = full[WIDTH];
        ssum  = longint'($signed(a_v)) + longint'($signed(b_v)) + longint'(c_v);
        exp_o = (ssum > SMAX) || (ssum < SMIN);

        @(posedge clk); #1;
        in_valid = 1'b1; a_i = a_v; b_i = b_v; cin_i = c_v;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);

        @(posedge clk); #1;   // accept edge
        in_valid = 1'b0;
        a_i = $urandom; b_i = $urandom; cin_i = 1'($urandom);
        chk("in_ready_busy", 64'(in_ready), 64'd0);

        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(NCHUNK));
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("sum", 64'(s_o), 64'(exp_s));
        chk("cout", 64'(cout_o), 64'(exp_c));
`ifdef SEQ_ADDER_OVF_EN
        chk("ovf", 64'(ovf_o), 64'(exp_o));
`endif

        if (hold > 0) begin
            in_valid = 1'b1;
            a_i = $urandom; b_i = $urandom;
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_sum", 64'(s_o), 64'(exp_s));
            chk("hold_cout", 64'(cout_o), 64'(exp_c));
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_hs_valid", 64'(out_valid), 64'd0);
        chk("post_hs_in_ready", 64'(in_ready), 64'd1);

        $display("op a=0x%08h b=0x%08h cin=%0d -> s=0x%08h cout=%0d exp_s=0x%08h exp_c=%0d ovf_exp=%0d lat=%0d hold=%0d",
                 a_v, b_v, c_v, s_o, cout_o, exp_s, exp_c, exp_o, lat, hold);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(s_o), 64'd0);
        chk("rst_cout", 64'(cout_o), 64'd0);
`ifdef SEQ_ADDER_OVF_EN
        chk("rst_ovf", 64'(ovf_o), 64'd0);
`endif
        $display("reset: in_ready=%0d out_valid=%0d s=0x%08h cout=%0d", in_ready, out_valid, s_o, cout_o);

        // Directed cases
        do_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 5);
        do_op(32'h00FF_00FF, 32'h0001_0001, 1'b1, 2);

        // Reset asserted in the middle of RUN
        @(posedge clk); #1;
        in_valid = 1'b1; a_i = 32'h1234_5678; b_i = 32'h1111_1111; cin_i = 1'b0;
        @(posedge clk); #1;   // accept edge
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_sum", 64'(s_o), 64'd0);
        chk("midrst_cout", 64'(cout_o), 64'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("midrst_no_emit", 64'(out_valid), 64'd0);
        end
        $display("reset mid-run: out_valid=%0d in_ready=%0d s=0x%08h", out_valid, in_ready, s_o);
        do_op(32'h0000_0001, 32'h0000_0002, 1'b0, 0);

        // Randomized operands, with some biased toward long carry chains
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 4 == 1) rb = ~ra;
            if (n % 4 == 2) rb = ~ra + WIDTH'($urandom_range(0, 2));
            do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
